// File: rtl/lcd_timing_pkg.sv
// Shared constants for the LCD/HDMI display timing generator.
// Defaults describe 640x480@60 (800x525 total, negative syncs).
package lcd_timing_pkg;

  // Total length of one axis: active + front porch + sync + back porch.
  function automatic int axis_total(input int res, input int fp,
                                    input int sync, input int bp);
    return res + fp + sync + bp;
  endfunction

  localparam int DEF_H_RES  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  // Sync active level: 0 = active-low.
  localparam bit DEF_H_POL  = 1'b0;
  localparam bit DEF_V_POL  = 1'b0;

  // Counter width; 2**CW must exceed both totals.
  localparam int DEF_CW     = 12;

  localparam int DEF_H_TOTAL = axis_total(DEF_H_RES, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_RES, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Sync windows are half-open: [start, end).
  localparam int DEF_H_SYNC_START = DEF_H_RES + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_RES + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/lcd_timing_axis_counter.sv
// One axis (horizontal or vertical) of the display timing generator.
// Holds the position register and the registered sync level; exposes the
// next-cycle active flag so the top can register a single aligned data enable,
// and a wrap flag that advances the next axis.
module lcd_timing_axis_counter #(
  parameter int CW         = 12,
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter bit POL        = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_advance,
  output logic [CW-1:0] o_count,
  output logic          o_sync,
  output logic          o_active_nxt,
  output logic          o_wrap
);

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_LO = CW'(SYNC_START);
  localparam logic [CW-1:0] SYNC_HI = CW'(SYNC_END);

  logic [CW-1:0] count_nxt;
  logic          sync_nxt;

  // Next position and the decodes that describe it.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    count_nxt    = o_count;
    o_wrap       = i_advance && (o_count == LAST);
    if (i_advance) begin
      count_nxt = o_wrap ? '0 : o_count + 1'b1;
    end
    o_active_nxt = (count_nxt < ACT_END);
    sync_nxt     = ((count_nxt >= SYNC_LO) && (count_nxt < SYNC_HI)) ? POL : !POL;
  end

  // Position and sync level; reset parks on the last position so the first
  // advance lands on 0 with no partial period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= LAST;
      o_sync  <= !POL;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      o_count <= count_nxt;
      o_sync  <= sync_nxt;
    end
  end

endmodule

// File: rtl/lcd_display_timing.sv
// Video timing generator for the HDMI/LCD output path (pixel clock domain).
// Counters advance only on i_pix_en cycles; all outputs are registered and
// describe the same (o_sx, o_sy) position in any given cycle.
// Optional line/frame strobes are built with DISPLAY_TIMING_STROBE_EN.
module lcd_display_timing
  import lcd_timing_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_RES  = DEF_V_RES,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter bit H_POL  = DEF_H_POL,
  parameter bit V_POL  = DEF_V_POL,
  parameter int CW     = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pix_en,
  output logic [CW-1:0] o_sx,
  output logic [CW-1:0] o_sy,
  output logic          o_de,
  output logic          o_hsync,
  output logic          o_vsync
`ifdef DISPLAY_TIMING_STROBE_EN
  ,
  output logic          o_line,
  output logic          o_frame
`endif
);

  localparam int H_TOTAL = axis_total(H_RES, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_RES, V_FP, V_SYNC, V_BP);

  logic h_wrap;
  logic h_active_nxt;
  logic v_active_nxt;
`ifdef DISPLAY_TIMING_STROBE_EN
  logic v_wrap;
`else
  // Frame wrap is only consumed by the frame strobe.
  logic unused_v_wrap;
`endif

  lcd_timing_axis_counter #(
    .CW         (CW),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_RES),
    .SYNC_START (H_RES + H_FP),
    .SYNC_END   (H_RES + H_FP + H_SYNC),
    .POL        (H_POL)
  ) u_h_axis (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_advance    (i_pix_en),
    .o_count      (o_sx),
    .o_sync       (o_hsync),
    .o_active_nxt (h_active_nxt),
    .o_wrap       (h_wrap)
  );

  // Vertical axis steps once per horizontal wrap, so vsync changes at o_sx = 0.
  lcd_timing_axis_counter #(
    .CW         (CW),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_RES),
    .SYNC_START (V_RES + V_FP),
    .SYNC_END   (V_RES + V_FP + V_SYNC),
    .POL        (V_POL)
  ) u_v_axis (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_advance    (h_wrap),
    .o_count      (o_sy),
    .o_sync       (o_vsync),
    .o_active_nxt (v_active_nxt),
`ifdef DISPLAY_TIMING_STROBE_EN
    .o_wrap       (v_wrap)
`else
    .o_wrap       (unused_v_wrap)
`endif
  );

  // Data enable registered from the next position so it lines up with o_sx/o_sy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_de <= 1'b0;
    end else begin
      o_de <= h_active_nxt && v_active_nxt;
    end
  end

`ifdef DISPLAY_TIMING_STROBE_EN
  // Strobes fire only on the edge that enters the position; any idle cycle clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end else begin
      o_line  <= h_wrap;
      o_frame <= h_wrap && v_wrap;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_display_timing.sv
// Self-checking bench for lcd_display_timing.
// Three instances share stimulus: default 640x480 timing, a small 25x14 raster
// (so whole frames fit in a short run) and the same small raster with positive
// syncs. A position model derived from the count of enables since reset is
// compared with every instance on each falling clock edge.
module tb_lcd_display_timing;

  typedef struct {
    int hr, hf, hs, hb, vr, vf, vs, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic [11:0] sx;
    logic [11:0] sy;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ln;
    logic        fr;
  } obs_t;

  cfg_t cfg_def = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  cfg_t cfg_sml = '{16, 2, 3, 4, 8, 1, 2, 3, 1'b0, 1'b0};
  cfg_t cfg_inv = '{16, 2, 3, 4, 8, 1, 2, 3, 1'b1, 1'b1};

  logic i_clk    = 1'b0;
  logic i_rst_n  = 1'b1;
  logic i_pix_en = 1'b0;

  always #5 i_clk = ~i_clk;

  logic [11:0] def_sx, def_sy, sml_sx, sml_sy, inv_sx, inv_sy;
  logic def_de, def_hs, def_vs, def_ln, def_fr;
  logic sml_de, sml_hs, sml_vs, sml_ln, sml_fr;
  logic inv_de, inv_hs, inv_vs, inv_ln, inv_fr;

  lcd_display_timing u_def (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pix_en(i_pix_en),
    .o_sx    (def_sx),
    .o_sy    (def_sy),
    .o_de    (def_de),
    .o_hsync (def_hs),
    .o_vsync (def_vs)
`ifdef DISPLAY_TIMING_STROBE_EN
    ,
    .o_line  (def_ln),
    .o_frame (def_fr)
`endif
  );

  lcd_display_timing #(
    .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_RES(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b0), .CW(12)
  ) u_sml (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pix_en(i_pix_en),
    .o_sx    (sml_sx),
    .o_sy    (sml_sy),
    .o_de    (sml_de),
    .o_hsync (sml_hs),
    .o_vsync (sml_vs)
`ifdef DISPLAY_TIMING_STROBE_EN
    ,
    .o_line  (sml_ln),
    .o_frame (sml_fr)
`endif
  );

  lcd_display_timing #(
    .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_RES(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b1), .CW(12)
  ) u_inv (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pix_en(i_pix_en),
    .o_sx    (inv_sx),
    .o_sy    (inv_sy),
    .o_de    (inv_de),
    .o_hsync (inv_hs),
    .o_vsync (inv_vs)
`ifdef DISPLAY_TIMING_STROBE_EN
    ,
    .o_line  (inv_ln),
    .o_frame (inv_fr)
`endif
  );

`ifndef DISPLAY_TIMING_STROBE_EN
  assign def_ln = 1'b0;
  assign def_fr = 1'b0;
  assign sml_ln = 1'b0;
  assign sml_fr = 1'b0;
  assign inv_ln = 1'b0;
  assign inv_fr = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      if (n_errors >= 40) finish_run();
    end
  endtask

  // Reference: number of accepted enables since reset fixes the position.
  longint n_adv;
  bit     adv_last;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_adv    <= 0;
      adv_last <= 1'b0;
    end else begin
      adv_last <= i_pix_en;
      if (i_pix_en) n_adv <= n_adv + 1;
    end
  end

  function automatic obs_t model(input cfg_t c, input longint n, input bit adv);
    obs_t   e;
    int     ht, vt, x, y;
    longint k;
    ht = c.hr + c.hf + c.hs + c.hb;
    vt = c.vr + c.vf + c.vs + c.vb;
    if (n == 0) begin
      x = ht - 1;
      y = vt - 1;
    end else begin
      k = (n - 1) % longint'(ht * vt);
      x = int'(k % ht);
      y = int'(k / ht);
    end
    e.sx = 12'(x);
    e.sy = 12'(y);
    e.de = (x < c.hr) && (y < c.vr);
    e.hs = (x >= c.hr + c.hf && x < c.hr + c.hf + c.hs) ? c.hp : !c.hp;
    e.vs = (y >= c.vr + c.vf && y < c.vr + c.vf + c.vs) ? c.vp : !c.vp;
    e.ln = 1'b0;
    e.fr = 1'b0;
`ifdef DISPLAY_TIMING_STROBE_EN
    e.ln = adv && (n != 0) && (x == 0);
    e.fr = adv && (n != 0) && (x == 0) && (y == 0);
`endif
    return e;
  endfunction

  function automatic obs_t pack_obs(input logic [11:0] sx, input logic [11:0] sy,
                                    input logic de, input logic hs, input logic vs,
                                    input logic ln, input logic fr);
    obs_t o;
    o.sx = sx; o.sy = sy; o.de = de; o.hs = hs; o.vs = vs; o.ln = ln; o.fr = fr;
    return o;
  endfunction

  // Per-cycle comparison of every instance (fields packed sx,sy,de,hs,vs,line,frame).
  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("cycle_def", 32'(pack_obs(def_sx, def_sy, def_de, def_hs, def_vs, def_ln, def_fr)),
            32'(model(cfg_def, n_adv, adv_last)));
      check("cycle_sml", 32'(pack_obs(sml_sx, sml_sy, sml_de, sml_hs, sml_vs, sml_ln, sml_fr)),
            32'(model(cfg_sml, n_adv, adv_last)));
      check("cycle_inv", 32'(pack_obs(inv_sx, inv_sy, inv_de, inv_hs, inv_vs, inv_ln, inv_fr)),
            32'(model(cfg_inv, n_adv, adv_last)));
    end
  end

  task automatic wait_def_sx(input int tgt, input int budget);
    for (int i = 0; i < budget && int'(def_sx) != tgt; i++) @(negedge i_clk);
    check($sformatf("reach_def_sx_%0d", tgt), 32'(def_sx), 32'(tgt));
  endtask

  task automatic wait_sml_pos(input int x, input int y, input int budget);
    for (int i = 0; i < budget && !(int'(sml_sx) == x && int'(sml_sy) == y); i++)
      @(negedge i_clk);
    check($sformatf("reach_sml_%0d_%0d", x, y), 32'({sml_sx, sml_sy}), 32'({12'(x), 12'(y)}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, de_cnt, vs_lo, hs_lo, ln_cnt, fr_cnt;
    bit prev_zero, found;

    // Reset and idle: parked on the last position, syncs inactive.
    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_def_sx", 32'(def_sx), 32'd799);
    check("rst_def_sy", 32'(def_sy), 32'd524);
    check("rst_def_de", 32'(def_de), 32'd0);
    check("rst_def_hs", 32'(def_hs), 32'd1);
    check("rst_def_vs", 32'(def_vs), 32'd1);
    check("rst_inv_hs", 32'(inv_hs), 32'd0);
    check("rst_inv_vs", 32'(inv_vs), 32'd0);
    cmp_en = 1'b1;

    // Release with the enable tied high: first edge shows (0,0), active.
    i_rst_n  = 1'b1;
    i_pix_en = 1'b1;
    @(negedge i_clk);
    check("first_def_pos", 32'({def_sx, def_sy}), 32'd0);
    check("first_def_de",  32'(def_de), 32'd1);
    check("first_sml_pos", 32'({sml_sx, sml_sy}), 32'd0);

    // Hsync window edges on the default raster, then the line period.
    wait_def_sx(655, 900);
    check("hs_655", 32'(def_hs), 32'd1);
    @(negedge i_clk);
    check("hs_656", 32'(def_hs), 32'd0);
    wait_def_sx(751, 900);
    check("hs_751", 32'(def_hs), 32'd0);
    @(negedge i_clk);
    check("hs_752", 32'(def_hs), 32'd1);
    wait_def_sx(0, 900);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (def_sx != 12'd0 && n < 2000);
    check("line_period", 32'(n), 32'd800);

    // One whole small frame: period and active/sync populations.
    wait_sml_pos(0, 0, 400);
    n = 0; de_cnt = 0; vs_lo = 0; hs_lo = 0;
    do begin
      @(negedge i_clk);
      n++;
      de_cnt += int'(sml_de);
      vs_lo  += int'(!sml_vs);
      hs_lo  += int'(!sml_hs);
    end while (!(sml_sx == 12'd0 && sml_sy == 12'd0) && n < 1000);
    check("sml_frame_period", 32'(n), 32'd350);
    check("sml_de_count",     32'(de_cnt), 32'd128);
    check("sml_vs_low_count", 32'(vs_lo), 32'd50);
    check("sml_hs_low_count", 32'(hs_lo), 32'd42);

    // Asynchronous reset mid-line: outputs drop without a clock edge.
    wait_def_sx(300, 900);
    #1 i_rst_n = 1'b0;
    #1;
    check("async_def_pos", 32'({def_sx, def_sy}), 32'({12'd799, 12'd524}));
    check("async_def_de",  32'(def_de), 32'd0);
    check("async_def_hs",  32'(def_hs), 32'd1);
    check("async_def_vs",  32'(def_vs), 32'd1);
    check("async_inv_hs",  32'(inv_hs), 32'd0);
    @(negedge i_clk);

    // Resume with a 1-of-4 enable and time one small frame between (0,0) entries.
    i_rst_n = 1'b1;
    n = 0;
    found = 1'b0;
    prev_zero = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      i_pix_en = (k % 4 == 0);
      @(negedge i_clk);
      if (k == 0) check("resume_def_pos", 32'({def_sx, def_sy}), 32'd0);
      if (k > 0) n++;
      if (k > 0 && !prev_zero && sml_sx == 12'd0 && sml_sy == 12'd0) found = 1'b1;
      prev_zero = (sml_sx == 12'd0 && sml_sy == 12'd0);
    end
    check("sml_frame_period_1of4", 32'(n), 32'd1400);

    // Step single enables to the last small position, pulse once, then hold idle.
    i_pix_en = 1'b0;
    @(negedge i_clk);
    for (int k = 0; k < 400 && !(sml_sx == 12'd24 && sml_sy == 12'd13); k++) begin
      i_pix_en = 1'b1;
      @(negedge i_clk);
      i_pix_en = 1'b0;
    end
    check("sml_last_pos", 32'({sml_sx, sml_sy}), 32'({12'd24, 12'd13}));
    i_pix_en = 1'b1;
    @(negedge i_clk);
    i_pix_en = 1'b0;
    ln_cnt = int'(sml_ln);
    fr_cnt = int'(sml_fr);
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      check("sml_hold_pos", 32'({sml_sx, sml_sy}), 32'd0);
      ln_cnt += int'(sml_ln);
      fr_cnt += int'(sml_fr);
    end
`ifdef DISPLAY_TIMING_STROBE_EN
    check("sml_line_strobes",  32'(ln_cnt), 32'd1);
    check("sml_frame_strobes", 32'(fr_cnt), 32'd1);
`else
    check("sml_no_strobes", 32'(ln_cnt + fr_cnt), 32'd0);
`endif

    cmp_en = 1'b0;
    finish_run();
  end

endmodule
